// File: rtl/dmem_pkg.sv
// Shared types for the dmem_latency data-memory model: handshake FSM states
// and the byte-offset helper used to split a byte address into a word index.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    function automatic int byte_off(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-lane write enables and a registered read port.
// No handshake logic here; the top level decides when to write or read.
module dmem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    ph1,
    input  logic                    reset,
    input  logic [DEPTH_LOG2-1:0]   idx,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [DATA_W/8-1:0]     lane_we,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Contents are deliberately not reset.
    always_ff @(posedge ph1) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_latency.sv
// Data memory with req/ack handshake and fixed access latency.
// Define DMEM_RANGE_CHECK_EN to reject out-of-range or misaligned addresses with err.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready; req accepted and captured
// ST_WAIT | latency counter running, busy
// ST_DONE | ack (and err if rejected) for one cycle, busy
module dmem_latency
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_W     = 32,
    parameter int LATENCY    = 3
) (
    input  logic                    ph1,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       adr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [DATA_W/8-1:0]     byteen,
    output logic [DATA_W-1:0]       rdata,
    output logic                    ack,
    output logic                    busy,
    output logic                    err
);

    localparam int BYTE_OFF = byte_off(DATA_W);
    localparam int LANES    = DATA_W / 8;
    localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ((ADDR_W'(1) << DEPTH_LOG2) - ADDR_W'(1)) << BYTE_OFF;

    dmem_state_e state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   we_q;
    logic                   rej_q;
    logic [DEPTH_LOG2-1:0]  idx_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [LANES-1:0]       byteen_q;
    logic                   err_q;
    logic                   zero_q;

    logic                   accept;
    logic                   fire;
    logic                   rej_live;
    logic [DEPTH_LOG2-1:0]  idx_live;
    logic                   cur_we;
    logic                   cur_rej;
    logic [DEPTH_LOG2-1:0]  cur_idx;
    logic [DATA_W-1:0]      cur_wdata;
    logic [LANES-1:0]       cur_byteen;
    logic [LANES-1:0]       lane_we;
    logic                   rd_en;
    logic [DATA_W-1:0]      arr_rdata;

    assign idx_live = adr[DEPTH_LOG2+BYTE_OFF-1:BYTE_OFF];

`ifdef DMEM_RANGE_CHECK_EN
    assign rej_live = |(adr & ~WORD_MASK);
`else
    assign rej_live = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && req;
    // fire marks the edge that enters ST_DONE; with LATENCY=1 that is the accept edge itself
    assign fire   = (accept && (LATENCY == 1)) || ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));

    assign cur_we     = (state_q == ST_IDLE) ? we       : we_q;
    assign cur_rej    = (state_q == ST_IDLE) ? rej_live : rej_q;
    assign cur_idx    = (state_q == ST_IDLE) ? idx_live : idx_q;
    assign cur_wdata  = (state_q == ST_IDLE) ? wdata    : wdata_q;
    assign cur_byteen = (state_q == ST_IDLE) ? byteen   : byteen_q;

    assign lane_we = (fire && reset && cur_we && !cur_rej) ? cur_byteen : '0;
    assign rd_en   = fire && !cur_we && !cur_rej;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = (LATENCY > 1) ? ST_WAIT : ST_DONE;
            ST_WAIT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            rej_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q    <= CNT_LOAD;
                we_q     <= we;
                rej_q    <= rej_live;
                idx_q    <= idx_live;
                wdata_q  <= wdata;
                byteen_q <= byteen;
            end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (fire) begin
                err_q <= cur_rej;
                // a rejected read forces rdata to zero until the next read completes
                if (!cur_we) zero_q <= cur_rej;
            end
        end
    end

    dmem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .ph1     (ph1),
        .reset   (reset),
        .idx     (cur_idx),
        .wdata   (cur_wdata),
        .lane_we (lane_we),
        .rd_en   (rd_en),
        .rd_data (arr_rdata)
    );

    assign rdata = zero_q ? '0 : arr_rdata;
    assign ack   = (state_q == ST_DONE);
    assign busy  = (state_q != ST_IDLE);
    assign err   = ack && err_q;

endmodule
